// File: rtl/multicycle_control_if.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control_if
// Purpose  : Groups the opcode/wait-state inputs and all datapath control
//            outputs of the multicycle MIPS control FSM into one bundle.
// Revision : 1.0 - initial release
//
// Signals
//   opcode      6  instruction[31:26] from the instruction register
//   mem_ready   1  memory completes the current access this cycle
//   PCWrite     1  unconditional PC load
//   PCWriteCond 1  PC load if ALU zero (beq)
//   IorD        1  memory address select: 0 = PC, 1 = ALUOut
//   MemRead     1  memory read request
//   MemWrite    1  memory write request
//   IRWrite     1  instruction register load
//   MemtoReg    1  register write data: 0 = ALUOut, 1 = MDR
//   RegDst      1  destination register: 0 = rt, 1 = rd
//   RegWrite    1  register file write enable
//   ALUSrcA     1  0 = PC, 1 = register A
//   ALUSrcB     2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//   PCSource    2  00 = ALU result, 01 = ALUOut, 10 = jump target
//   ALUOp       2  00 add, 01 subtract, 10 use funct
//   illegal     1  one-cycle pulse on an unrecognised opcode
//   state       4  current state encoding (debug)
//
// Modports
//   master : the control FSM (drives the control outputs)
//   slave  : the datapath / memory side (drives opcode and mem_ready)
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, illegal, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control
// Purpose  : Main control FSM of the multicycle MIPS datapath. Sequences each
//            instruction through fetch, decode, execute, memory and write-back
//            and drives every datapath select and enable. Memory accesses in
//            FETCH, MEMRD and MEMWR hold until mem_ready.
// Revision : 1.0 - initial release
//
// Ports
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset (forces FETCH)
//   bus    -   -  multicycle_control_if.master: opcode/mem_ready in,
//                 all datapath controls, illegal and debug state out
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic       illegal;

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle, but the PC and IR only load
        // on the cycle the memory actually returns the instruction.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only lw/sw reach here, so anything but lw is a store.
        state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end

      // Unused encodings recover to FETCH.
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCWriteCond = pc_write_cond;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IRWrite     = ir_write;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegDst      = reg_dst;
  assign bus.RegWrite    = reg_write;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.PCSource    = pc_source;
  assign bus.ALUOp       = alu_op;
  assign bus.illegal     = illegal;
  assign bus.state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control. Each instruction is
//            expanded into the cycle-by-cycle state walk it should take; the
//            expected state and control word of every cycle is queued and a
//            monitor compares it against the DUT on the falling edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  typedef struct {
    logic [3:0] st;
    bit         mr;
  } step_t;

  exp_t  sb[$];
  step_t plan[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc_no   = 0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
  //                MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUOp,illegal}
  wire [16:0] act_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                         bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                         bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                         bus.ALUOp, bus.illegal};

  // Reference: the per-state output table of the control unit.
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input bit mr,
                                          input logic [5:0] opc);
    bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    bit m2r = 0, rdst = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00, aop = 2'b00;
    case (st)
      4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin
        asb = 2'b11;
        ill = !(opc == OP_R || opc == OP_LW || opc == OP_SW ||
                opc == OP_BEQ || opc == OP_J);
      end
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; iord = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rdst = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop, ill};
  endfunction

  // Expand one instruction into its state walk.
  // wf: FETCH wait cycles, wm: MEMRD/MEMWR wait cycles.
  task automatic build_plan(input logic [5:0] opc, input int wf, input int wm);
    plan.delete();
    for (int i = 0; i < wf; i++) plan.push_back('{4'd0, 1'b0});
    plan.push_back('{4'd0, 1'b1});
    plan.push_back('{4'd1, 1'($urandom)});
    if (opc == OP_LW) begin
      plan.push_back('{4'd2, 1'($urandom)});
      for (int i = 0; i < wm; i++) plan.push_back('{4'd3, 1'b0});
      plan.push_back('{4'd3, 1'b1});
      plan.push_back('{4'd4, 1'($urandom)});
    end else if (opc == OP_SW) begin
      plan.push_back('{4'd2, 1'($urandom)});
      for (int i = 0; i < wm; i++) plan.push_back('{4'd5, 1'b0});
      plan.push_back('{4'd5, 1'b1});
    end else if (opc == OP_R) begin
      plan.push_back('{4'd6, 1'($urandom)});
      plan.push_back('{4'd7, 1'($urandom)});
    end else if (opc == OP_BEQ) begin
      plan.push_back('{4'd8, 1'($urandom)});
    end else if (opc == OP_J) begin
      plan.push_back('{4'd9, 1'($urandom)});
    end
  endtask

  // Drive one cycle's inputs and queue what the DUT must show this cycle.
  task automatic cyc(input logic [3:0] st, input logic [5:0] opc, input bit mr,
                     input bit rn);
    exp_t e;
    @(posedge clk);
    #1;
    bus.opcode    = opc;
    bus.mem_ready = mr;
    rst_n         = rn;
    e.st  = st;
    e.ctl = exp_ctl(st, mr, opc);
    sb.push_back(e);
  endtask

  // Run one instruction; if abort_st occurs in its walk, rst_n is pulled low
  // in that cycle and held for rcyc cycles in total (the rest are in FETCH).
  task automatic run_instr(input logic [5:0] opc, input int wf, input int wm,
                           input int abort_st, input int rcyc, input bit rmr_rand);
    logic [5:0] o;
    build_plan(opc, wf, wm);
    for (int i = 0; i < plan.size(); i++) begin
      o = (plan[i].st == 4'd0) ? 6'($urandom) : opc;
      if (int'(plan[i].st) == abort_st) begin
        cyc(plan[i].st, o, plan[i].mr, 1'b0);
        for (int k = 1; k < rcyc; k++)
          cyc(4'd0, 6'($urandom), rmr_rand ? 1'($urandom) : 1'b1, 1'b0);
        return;
      end
      cyc(plan[i].st, o, plan[i].mr, 1'b1);
    end
  endtask

  // Monitor: compare every queued cycle away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.state !== e.st) begin
          failures++;
          $display("FAIL state cycle=%0d actual=%0d required=%0d", cyc_no, bus.state, e.st);
        end
        checks++;
        if (act_ctl !== e.ctl) begin
          failures++;
          $display("FAIL ctl state=%0d cycle=%0d actual=%b required=%b",
                   e.st, cyc_no, act_ctl, e.ctl);
        end
      end
    end
  end

  initial begin
    logic [5:0] opc;
    int         pick;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);

    // Reset from state 7 with mem_ready=1, held two cycles.
    run_instr(OP_R, 0, 0, 7, 2, 1'b0);
    // R-type.
    run_instr(OP_R, 0, 0, -1, 0, 1'b0);
    // lw with three MEMRD wait cycles.
    run_instr(OP_LW, 0, 3, -1, 0, 1'b0);
    // sw with two FETCH wait cycles.
    run_instr(OP_SW, 2, 0, -1, 0, 1'b0);
    // beq then j.
    run_instr(OP_BEQ, 0, 0, -1, 0, 1'b0);
    run_instr(OP_J, 0, 0, -1, 0, 1'b0);
    // Illegal opcode.
    run_instr(6'b111111, 0, 0, -1, 0, 1'b0);
    // Reset during a MEMWR wait (first MEMWR cycle has mem_ready=0).
    run_instr(OP_SW, 0, 2, 5, 1, 1'b0);
    run_instr(OP_R, 0, 0, -1, 0, 1'b0);

    // Randomised instruction stream with occasional resets.
    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: opc = OP_R;
        1: opc = OP_LW;
        2: opc = OP_SW;
        3: opc = OP_BEQ;
        4: opc = OP_J;
        default: opc = 6'($urandom);
      endcase
      run_instr(opc,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : -1,
                $urandom_range(1, 3), 1'b1);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
